// File: rtl/otp_sequencer_pkg.sv
// Shared definitions for the OTP sequencer slice: block sizing and FSM state encoding.
package otp_sequencer_pkg;

    localparam int TEXT_SIZE_BYTES = 4;
    localparam int TEXT_SIZE_BITS  = 8 * TEXT_SIZE_BYTES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/otp_sequencer_if.sv
// Request/result handshake bundle between the text input stage, the sequencer and the output stage.
interface otp_sequencer_if #(parameter int TEXT_BYTES = 4);

    logic                    in_valid;
    logic                    in_ready;
    logic [7:0]              seed;
    logic [3:0]              rounds;
    logic [8*TEXT_BYTES-1:0] text_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [8*TEXT_BYTES-1:0] cipher_out;
    logic [8*TEXT_BYTES-1:0] key_out;
    logic                    busy;
    logic [7:0]              blk_count;

    modport master (
        output in_valid, seed, rounds, text_in, out_ready,
        input  in_ready, out_valid, cipher_out, key_out, busy, blk_count
    );

    modport slave (
        input  in_valid, seed, rounds, text_in, out_ready,
        output in_ready, out_valid, cipher_out, key_out, busy, blk_count
    );

endinterface

// File: rtl/otp_keygen.sv
// Key register: loads the seed+i byte pattern or rotates right by one byte per edge.
module otp_keygen #(
    parameter int TEXT_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    rot,
    input  logic [7:0]              seed,
    output logic [8*TEXT_BYTES-1:0] key
);

    localparam int TEXT_BITS = 8 * TEXT_BYTES;

    logic [TEXT_BITS-1:0] key_r;

    function automatic logic [TEXT_BITS-1:0] seed_pattern(input logic [7:0] s);
        logic [TEXT_BITS-1:0] p;
        p = '0;
        for (int i = 0; i < TEXT_BYTES; i++) begin
            p[8*i +: 8] = s + 8'(i);
        end
        return p;
    endfunction

    // Key register update; load takes priority over rotate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_r <= '0;
        end else if (load) begin
            key_r <= seed_pattern(seed);
        end else if (rot) begin
            key_r <= {key_r[7:0], key_r[TEXT_BITS-1:8]};
        end else begin
            key_r <= key_r;
        end
    end

    assign key = key_r;

endmodule

// File: rtl/otp_sequencer.sv
// OTP sequencer: accepts a block, rotates the seed-derived key for the requested rounds, emits text ^ key.
module otp_sequencer
    import otp_sequencer_pkg::*;
#(
    parameter int TEXT_BYTES = TEXT_SIZE_BYTES
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    otp_sequencer_if.slave bus
);

    localparam int TEXT_BITS = 8 * TEXT_BYTES;

    state_t               state_r;
    logic [3:0]           cnt_r;
    logic [TEXT_BITS-1:0] text_r;
    logic [7:0]           blk_count_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 busy_r;
    logic [TEXT_BITS-1:0] key_s;
    logic                 load_s;
    logic                 rot_s;

    // Key generator strobes; clear suppresses both so an aborted block never touches the key.
    always_comb begin
        load_s = 1'b0;
        rot_s  = 1'b0;
        if (clear) begin
            load_s = 1'b0;
            rot_s  = 1'b0;
        end else begin
            load_s = (state_r == ST_IDLE) && bus.in_valid;
            rot_s  = (state_r == ST_SHIFT);
        end
    end

    otp_keygen #(.TEXT_BYTES(TEXT_BYTES)) u_keygen (
        .clk   (clk),
        .reset (reset),
        .load  (load_s),
        .rot   (rot_s),
        .seed  (bus.seed),
        .key   (key_s)
    );

    // Sequencing FSM with registered handshake/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            text_r      <= '0;
            blk_count_r <= 8'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (clear) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        text_r     <= bus.text_in;
                        cnt_r      <= bus.rounds;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (bus.rounds != 4'd0) begin
                            state_r     <= ST_SHIFT;
                            out_valid_r <= 1'b0;
                        end else begin
                            state_r     <= ST_OUT;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r     <= ST_OUT;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_IDLE;
                        blk_count_r <= blk_count_r + 8'd1;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.busy       = busy_r;
    assign bus.blk_count  = blk_count_r;
    assign bus.key_out    = key_s;
    assign bus.cipher_out = text_r ^ key_s;

endmodule

// File: tb/tb_otp_sequencer.sv
// Directed bench for otp_sequencer with hand-computed expected values.
module tb_otp_sequencer;

    logic clk;
    logic reset;
    logic clear;
    int   total;
    int   bad;

    otp_sequencer_if #(.TEXT_BYTES(4)) bus ();

    otp_sequencer #(.TEXT_BYTES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        clear = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.seed      = 8'h00;
        bus.rounds    = 4'd0;
        bus.text_in   = 32'h0;

        // Reset state
        step();
        step();
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_key",       bus.key_out,        32'h0);
        chk("rst_cipher",    bus.cipher_out,     32'h0);
        chk("rst_blk",       32'(bus.blk_count), 32'd0);
        reset = 1'b0;
        step();

        // Single rotate
        bus.seed = 8'h10; bus.rounds = 4'd1; bus.text_in = 32'hFFFFFFFF; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("r1_load_key",   bus.key_out,        32'h13121110);
        chk("r1_shift_ov",   32'(bus.out_valid), 32'd0);
        chk("r1_shift_rdy",  32'(bus.in_ready),  32'd0);
        chk("r1_shift_busy", 32'(bus.busy),      32'd1);
        step();
        chk("r1_ov",     32'(bus.out_valid), 32'd1);
        chk("r1_key",    bus.key_out,        32'h10131211);
        chk("r1_cipher", bus.cipher_out,     32'hEFECEDEE);
        chk("r1_rdy",    32'(bus.in_ready),  32'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("r1_done_ov",  32'(bus.out_valid), 32'd0);
        chk("r1_done_rdy", 32'(bus.in_ready),  32'd1);
        chk("r1_blk",      32'(bus.blk_count), 32'd1);

        // Zero rounds
        bus.seed = 8'hA0; bus.rounds = 4'd0; bus.text_in = 32'h0; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("r0_ov",     32'(bus.out_valid), 32'd1);
        chk("r0_cipher", bus.cipher_out,     32'hA3A2A1A0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("r0_blk", 32'(bus.blk_count), 32'd2);

        // Backpressure with full-wrap rotation
        bus.seed = 8'h00; bus.rounds = 4'd4; bus.text_in = 32'h12345678; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_shift_ov", 32'(bus.out_valid), 32'd0);
            step();
        end
        chk("bp_last_shift_ov", 32'(bus.out_valid), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_ov",     32'(bus.out_valid), 32'd1);
            chk("bp_hold_rdy",    32'(bus.in_ready),  32'd0);
            chk("bp_hold_cipher", bus.cipher_out,     32'h11365778);
            chk("bp_hold_blk",    32'(bus.blk_count), 32'd2);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("bp_blk",     32'(bus.blk_count), 32'd3);
        chk("bp_done_ov", 32'(bus.out_valid), 32'd0);

        // Abort in the second SHIFT cycle with a competing in_valid
        bus.seed = 8'h55; bus.rounds = 4'd6; bus.text_in = 32'hDEADBEEF; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("ab_busy1", 32'(bus.busy), 32'd1);
        step();
        chk("ab_busy2", 32'(bus.busy), 32'd1);
        clear = 1'b1; bus.in_valid = 1'b1;
        step();
        clear = 1'b0; bus.in_valid = 1'b0;
        chk("ab_rdy",  32'(bus.in_ready),  32'd1);
        chk("ab_busy", 32'(bus.busy),      32'd0);
        chk("ab_ov",   32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("ab_after_ov", 32'(bus.out_valid), 32'd0);
            step();
        end
        chk("ab_blk", 32'(bus.blk_count), 32'd3);

        // 256 zero-round blocks wrap the counter back to its starting value
        for (int i = 0; i < 256; i++) begin
            bus.seed = 8'(i); bus.rounds = 4'd0; bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            if (i == 252) chk("wrap_zero", 32'(bus.blk_count), 32'd0);
        end
        chk("wrap_blk", 32'(bus.blk_count), 32'd3);

        // Asynchronous reset mid-SHIFT
        bus.seed = 8'h77; bus.rounds = 4'd5; bus.text_in = 32'hAAAAAAAA; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("ar_pre_busy", 32'(bus.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_rdy",    32'(bus.in_ready),  32'd1);
        chk("ar_busy",   32'(bus.busy),      32'd0);
        chk("ar_ov",     32'(bus.out_valid), 32'd0);
        chk("ar_key",    bus.key_out,        32'h0);
        chk("ar_cipher", bus.cipher_out,     32'h0);
        chk("ar_blk",    32'(bus.blk_count), 32'd0);
        #1;
        reset = 1'b0;
        step();
        chk("ar_after_rdy", 32'(bus.in_ready),  32'd1);
        chk("ar_after_ov",  32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
